// File: rtl/mac_job_sequencer_if.sv
// Job, operand, datapath-control and result signals of the MAC job sequencer.
// Latency: none; this is wiring only.
// Backpressure: start/in/out handshakes are valid/ready; the sequencer owns the ready side of start and in.
interface mac_job_sequencer_if #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int LEN_WIDTH      = 16
);
  logic                      start_valid;
  logic                      start_ready;
  logic [MAC_CONF_WIDTH-1:0] start_cfg;
  logic [LEN_WIDTH-1:0]      start_len;
  logic                      in_valid;
  logic                      in_ready;
  logic                      dp_en;
  logic [MAC_CONF_WIDTH-1:0] dp_cfg;
  logic                      dp_acc_clr;
  logic                      dp_acc_en;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic [LEN_WIDTH-1:0]      beat_count;

  // Host / stream front-end side.
  modport master (
    output start_valid, start_cfg, start_len, in_valid, out_ready,
    input  start_ready, in_ready, dp_en, dp_cfg, dp_acc_clr, dp_acc_en,
           out_valid, busy, beat_count
  );

  // Sequencer side.
  modport slave (
    input  start_valid, start_cfg, start_len, in_valid, out_ready,
    output start_ready, in_ready, dp_en, dp_cfg, dp_acc_clr, dp_acc_en,
           out_valid, busy, beat_count
  );
endinterface

// File: rtl/mac_job_sequencer.sv
// Sequences one MAC job at a time: latch cfg/len, admit beats, track them through the pipe, present result.
// Latency: start -> clear 1 cycle, first beat admitted 2 cycles after start, result PIPE_DEPTH+1 cycles after last beat.
// Backpressure: in_valid low inserts bubbles; out_valid holds until out_ready; no new job while a result is pending.
module mac_job_sequencer #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int LEN_WIDTH      = 16,
  parameter int PIPE_DEPTH     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_job_sequencer_if.slave   seq_if
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [MAC_CONF_WIDTH-1:0] cfg_q;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      cnt_q;
  logic [PIPE_DEPTH-1:0]     vld_q, vld_d;

  logic start_rdy;
  logic in_rdy;
  logic start_hs;
  logic issue;
  logic last_beat;
  logic dp_en_c;
  logic acc_clr_c;
  logic out_vld_c;

  // Ready signals are pure state decodes so no valid input can loop back into them.
  assign start_rdy = (state_q == IDLE);
  assign in_rdy    = (state_q == RUN);
  assign start_hs  = seq_if.start_valid & start_rdy;
  assign issue     = seq_if.in_valid & in_rdy;
  assign last_beat = (cnt_q == (len_q - LEN_WIDTH'(1)));

  // A mul job produces a single product, so it admits at most one beat.
  always_comb begin
    len_d = seq_if.start_len;
    if (!seq_if.start_cfg[2]) begin
      len_d = (seq_if.start_len != '0) ? LEN_WIDTH'(1) : '0;
    end
  end

  // Beat-occupancy shift register: one bit per pipeline stage, bubbles shift through as zeros.
  generate
    if (PIPE_DEPTH == 1) begin : g_vld_one
      always_comb vld_d = issue;
    end else begin : g_vld_many
      always_comb vld_d = {vld_q[PIPE_DEPTH-2:0], issue};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    state_d   = state_q;
    dp_en_c   = 1'b0;
    acc_clr_c = 1'b0;
    out_vld_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_hs) state_d = LOAD;
      end
      LOAD: begin
        acc_clr_c = 1'b1;
        state_d   = (len_q == '0) ? DRAIN : RUN;
      end
      RUN: begin
        dp_en_c = 1'b1;
        if (issue && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        dp_en_c = 1'b1;
        // Leave once the beat being captured this cycle is the last one in the pipe.
        if (vld_d == '0) state_d = DONE;
      end
      DONE: begin
        out_vld_c = 1'b1;
        if (seq_if.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Job registers: cfg/len latch only on a start handshake so cfg is frozen while data is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (start_hs) begin
        cfg_q <= seq_if.start_cfg;
        len_q <= len_d;
        cnt_q <= '0;
      end else if (issue) begin
        cnt_q <= cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  assign seq_if.start_ready = start_rdy;
  assign seq_if.in_ready    = in_rdy;
  assign seq_if.dp_en       = dp_en_c;
  assign seq_if.dp_cfg      = cfg_q;
  assign seq_if.dp_acc_clr  = acc_clr_c;
  assign seq_if.dp_acc_en   = vld_q[PIPE_DEPTH-1];
  assign seq_if.out_valid   = out_vld_c;
  assign seq_if.busy        = (state_q != IDLE);
  assign seq_if.beat_count  = cnt_q;

endmodule

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
Controller that sequences one MAC job at a time through the multiplier, the configurable negator and the accumulator pipeline. It accepts a job descriptor (cfg and beat count) via a valid/ready handshake and holds cfg stable in the datapath for the whole job. It admits operand beats, tracks beats in flight through a fixed-depth pipeline and generates accumulator clear/enable. When the pipeline has drained, it presents a result-valid handshake. It sits between the host or stream front-end and the MAC datapath.

Parameters:
MAC_CONF_WIDTH, 4, cfg width; bit3 signed(1)/unsigned(0), bit2 mac(1)/mul(0), bits[1:0] 00 single, 01 dual, 10 quad.
LEN_WIDTH, 16, width of the beat-count field.
PIPE_DEPTH, 3, cycles from beat issue to accumulator capture; must be ≥1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start_valid  in  1  job descriptor valid
start_ready  out  1  sequencer can accept a job
start_cfg  in  MAC_CONF_WIDTH  job configuration
start_len  in  LEN_WIDTH  number of operand beats in the job
in_valid  in  1  operand beat available on the datapath inputs
in_ready  out  1  sequencer admits the beat
dp_en  out  1  datapath pipeline enable
dp_cfg  out  MAC_CONF_WIDTH  registered cfg driven to multiplier, negator and accumulator
dp_acc_clr  out  1  accumulator clear pulse
dp_acc_en  out  1  accumulator capture enable for the beat exiting the pipeline
out_valid  out  1  accumulated result valid
out_ready  in  1  consumer accepts the result
busy  out  1  job in progress (state ≠ IDLE)
beat_count  out  LEN_WIDTH  beats admitted in the current job

Behaviour:
- States: IDLE, LOAD, RUN, DRAIN, DONE. Reset puts the block in IDLE.
- Reset values: dp_cfg=0, beat_count=0, vld shift register=0. All outputs deasserted except start_ready=1.
- rst is checked before all other logic. Reset mid-job abandons the job at once: in-flight beats are dropped, no out_valid is produced, and the next cycle is IDLE.
- IDLE: start_ready=1. A handshake (start_valid & start_ready) at cycle T latches the following:
  - cfg into dp_cfg.
  - len into len_q. In mul mode (cfg[2]=0), len_q is set to min(start_len,1).
  - beat_count cleared.
  - State moves to LOAD at T+1.
- dp_cfg changes only on a start handshake. It is constant from LOAD through DONE, so the negator carry chain never reconfigures while data is in flight.
- LOAD (1 cycle): dp_acc_clr=1. If len_q=0, go to DRAIN; otherwise go to RUN.
- RUN:
  - in_ready=1. Issue = in_valid & in_ready.
  - Each issue increments beat_count.
  - When an issue happens with beat_count = len_q-1, go to DRAIN next cycle. in_ready is 0 from that point.
  - in_valid low inserts a bubble, and the state stays RUN.
- vld register: vld[PIPE_DEPTH-1:0] updates every cycle as vld ← {vld[PIPE_DEPTH-2:0], issue}. For PIPE_DEPTH=1, vld ← issue.
- dp_acc_en = vld[PIPE_DEPTH-1]. A beat issued at cycle t is captured by the accumulator at t+PIPE_DEPTH.
- dp_en is 1 in RUN and DRAIN and 0 elsewhere. The pipeline always advances while dp_en=1; bubbles are tracked by vld.
- DRAIN: go to DONE when the next value of vld is all-zero. DONE is therefore entered the cycle after the last dp_acc_en.
- DONE: out_valid=1, held until out_ready is seen. The handshake at cycle D returns the state to IDLE at D+1. start_ready is 0 in DONE, so a new start cannot overlap the current result.
- busy=1 in every state except IDLE.
- beat_count never wraps: the maximum len is 2^LEN_WIDTH-1, and counting stops at len_q.
- in_ready and start_ready are pure state decodes with no combinational path from any valid input.

Test Plan:
1. cfg=4'b1110 (signed, mac, quad), len=4, in_valid held high, start at cycle 0:
   - dp_acc_clr at cycle 1.
   - in_ready during cycles 2–5.
   - dp_acc_en during cycles 5–8.
   - out_valid at cycle 9.
   - dp_cfg=4'b1110 throughout.
2. Same job with in_valid low on the 2nd and 3rd RUN cycles: exactly 4 issues and 4 dp_acc_en pulses, with gaps matching the bubbles; out_valid 2 cycles later than in test 1.
3. len=0: LOAD → DRAIN → DONE; dp_acc_clr pulses, no dp_acc_en, out_valid at cycle 3.
4. cfg=4'b0001 (mul, dual), len=5: only 1 beat is admitted, beat_count=1, a single dp_acc_en, then out_valid.
5. out_ready held low for 10 cycles in DONE: out_valid stays high, start_ready=0, and a start_valid pulse is ignored. One cycle after out_ready rises, the state is IDLE.
6. rst asserted during DRAIN with vld≠0: next cycle IDLE, dp_cfg=0, no dp_acc_en and no out_valid. A subsequent len=1 job completes normally.
